adder_tree_operand_loader: RTL and testbench

Source end of the adder tree's operand interface. Accepts a valid/ready stream of ADDER_WIDTH-bit words and deserialises 2**LEVELS of them into a stable parallel operand bus that drives adder_tree_top's isum inputs. Waits the tree's fixed pipeline latency, captures the tree's registered sum, and returns it on a valid/ready result port. One sum is in flight at a time.

---
 rtl/adder_tree_pkg.sv | 19 +
 rtl/adder_tree_operand_loader_if.sv | 27 ++
 rtl/adder_tree_operand_loader.sv | 143 ++++++++++++++
 tb/tb_adder_tree_operand_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants, loader state encoding and width helper for the adder-tree
// operand loader.
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEF = 16;
  localparam int LEVELS_DEF      = 3;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } loader_state_e;

  // Exact width of the sum of 2**l unsigned w-bit words.
  function automatic int sum_width(input int w, input int l);
    return w + l;
  endfunction

endpackage

// File: rtl/adder_tree_operand_loader_if.sv
// Operand input stream and sum result stream of the adder-tree operand loader.
// The loader uses the slave modport; the operand source / result sink uses master.
interface adder_tree_operand_loader_if
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int LEVELS      = LEVELS_DEF
);

  logic                                     in_valid;
  logic                                     in_ready;
  logic [ADDER_WIDTH-1:0]                   in_data;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [sum_width(ADDER_WIDTH, LEVELS)-1:0] out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/adder_tree_operand_loader.sv
// Deserialises 2**LEVELS operand words onto a parallel bus, waits the tree latency,
// and returns the captured sum. Define ADDER_TREE_LOADER_SELF_CHECK_EN for the sum self-check.
module adder_tree_operand_loader
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = ADDER_WIDTH_DEF,
  parameter int LEVELS       = LEVELS_DEF,
  parameter int TREE_LATENCY = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  adder_tree_operand_loader_if.slave                bus,
  output logic [(2**LEVELS)*ADDER_WIDTH-1:0]        op_bus,
  input  logic [sum_width(ADDER_WIDTH, LEVELS)-1:0] tree_sum,
  output logic [LEVELS-1:0]                         fill_level,
  output logic                                      err_mismatch
);

  localparam int N  = 2**LEVELS;
  localparam int SW = sum_width(ADDER_WIDTH, LEVELS);
  localparam int CW = (TREE_LATENCY < 1) ? 1 : $clog2(TREE_LATENCY + 1);

  localparam logic [CW-1:0]     LAT_INIT  = CW'(TREE_LATENCY);
  localparam logic [LEVELS-1:0] LAST_SLOT = LEVELS'(N - 1);

  loader_state_e                   state_q, state_d;
  logic [N-1:0][ADDER_WIDTH-1:0]   slot_q, slot_d;
  logic [LEVELS-1:0]               fill_q, fill_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic [SW-1:0]                   out_sum_q, out_sum_d;

  logic accept;
  logic capture;
  logic consume;

  assign accept  = bus.in_valid && in_ready_q;
  assign capture = (state_q == WAIT) && (cnt_q == '0);
  assign consume = out_valid_q && bus.out_ready;

  always_comb begin
    // NOTE: every _d signal takes its current value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          slot_d[fill_q] = bus.in_data;
          fill_d         = fill_q + 1'b1;  // wraps to 0 after the last slot
          if (fill_q == LAST_SLOT) begin
            cnt_d   = LAT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (capture) begin
          out_sum_d   = tree_sum;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (consume) begin
          out_valid_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // in_ready is registered: it follows the state being entered.
    in_ready_d = (state_d == FILL);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      // NOTE: the slot bank is reset because op_bus must read zero after reset; it is only N words of flops.
      slot_q      <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

`ifdef ADDER_TREE_LOADER_SELF_CHECK_EN
  logic [SW-1:0] acc_q, acc_d;
  logic          err_q, err_d;

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (accept) begin
      acc_d = (fill_q == '0) ? SW'(bus.in_data) : acc_q + SW'(bus.in_data);
    end
    // Sticky until reset: a single wrong tree result is enough to flag the tree.
    if (capture && (tree_sum != acc_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign op_bus        = slot_q;
  assign fill_level    = fill_q;

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Self-checking bench for adder_tree_operand_loader with a two-register adder tree stand-in.
`timescale 1ns/1ps
module tb_adder_tree_operand_loader;
  import adder_tree_pkg::*;

  localparam int W   = 16;
  localparam int L   = 3;
  localparam int LAT = 2;
  localparam int N   = 8;
  localparam int SW  = 19;
`ifdef ADDER_TREE_LOADER_SELF_CHECK_EN
  localparam bit SELF_CHECK = 1'b1;
`else
  localparam bit SELF_CHECK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  op_bus;
  logic [SW-1:0]   tree_sum;
  logic [L-1:0]    fill_level;
  logic            err_mismatch;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] grp [N];

  adder_tree_operand_loader_if #(.ADDER_WIDTH(W), .LEVELS(L)) bus ();

  adder_tree_operand_loader #(
    .ADDER_WIDTH (W),
    .LEVELS      (L),
    .TREE_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .op_bus      (op_bus),
    .tree_sum    (tree_sum),
    .fill_level  (fill_level),
    .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  // Adder tree stand-in: input register then sum register.
  function automatic logic [SW-1:0] add_words(input logic [N*W-1:0] b);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(b[k*W +: W]);
    return SW'(s);
  endfunction

  logic [N*W-1:0] tree_in;
  logic [SW-1:0]  tree_sum_r;
  bit             force_zero = 1'b0;

  always @(posedge clk) begin
    tree_in    <= op_bus;
    tree_sum_r <= add_words(tree_in);
  end

  assign tree_sum = force_zero ? '0 : tree_sum_r;

  // One group: words from grp, in_valid gaps with probability gap_pct%, result held
  // for hold_cycles before consuming. Called at a negedge, returns at a negedge.
  task automatic run_group(input string tag, input int gap_pct, input int hold_cycles,
                           input bit hold_valid, input bit tree_forced);
    int             idx;
    int             sum;
    int             cyc;
    int             lat;
    logic [SW-1:0]  exp_sum;
    logic [N*W-1:0] exp_bus;
    idx = 0;
    sum = 0;
    cyc = 0;
    for (int k = 0; k < N; k++) exp_bus[k*W +: W] = grp[k];
    while (idx < N && cyc < 2000) begin
      tests++;
      if (fill_level !== idx[L-1:0]) begin
        fails++;
        $display("FAIL %s fill_level: got %0d want %0d", tag, fill_level, idx);
      end
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s in_ready_fill: got %b want 1", tag, bus.in_ready);
      end
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_data  = grp[idx];
      if (bus.in_valid) begin
        sum += int'(grp[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (idx != N) begin
      fails++;
      $display("FAIL %s fill_timeout: got %0d words want %0d", tag, idx, N);
    end
    exp_sum = tree_forced ? '0 : SW'(sum);
    bus.in_valid = hold_valid;
    bus.in_data  = 16'hBEEF;

    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      tests++;
      if (bus.in_ready !== 1'b0 || fill_level !== '0) begin
        fails++;
        $display("FAIL %s wait_state: got in_ready=%b fill=%0d want 0/0", tag, bus.in_ready, fill_level);
      end
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != LAT + 1) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT + 1);
    end
    tests++;
    if (bus.out_sum !== exp_sum) begin
      fails++;
      $display("FAIL %s out_sum: got %h want %h", tag, bus.out_sum, exp_sum);
    end
    tests++;
    if (op_bus !== exp_bus) begin
      fails++;
      $display("FAIL %s op_bus_wait: got %h want %h", tag, op_bus, exp_bus);
    end

    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold: got valid=%b sum=%h ready=%b want 1/%h/0",
                 tag, bus.out_valid, bus.out_sum, bus.in_ready, exp_sum);
      end
      tests++;
      if (op_bus !== exp_bus || fill_level !== '0) begin
        fails++;
        $display("FAIL %s hold_bus: got %h fill=%0d want %h fill=0", tag, op_bus, fill_level, exp_bus);
      end
    end

    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || fill_level !== '0) begin
      fails++;
      $display("FAIL %s consume: got valid=%b ready=%b fill=%0d want 0/1/0",
               tag, bus.out_valid, bus.in_ready, fill_level);
    end
    tests++;
    if (op_bus !== exp_bus) begin
      fails++;
      $display("FAIL %s op_bus_idle: got %h want %h", tag, op_bus, exp_bus);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b valid=%b sum=%h want 1/0/0",
               bus.in_ready, bus.out_valid, bus.out_sum);
    end
    tests++;
    if (op_bus !== '0 || fill_level !== '0 || err_mismatch !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got bus=%h fill=%0d err=%b want 0/0/0", op_bus, fill_level, err_mismatch);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < N; k++) grp[k] = W'(k + 1);
    run_group("seq", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < N; k++) grp[k] = 16'hFFFF;
    run_group("ones", 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) grp[k] = W'(k + 1);
    run_group("bp", 0, 5, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < N; k++) grp[k] = W'($urandom);
      run_group("gaps", 40, int'($urandom_range(3)), 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < N; k++) grp[k] = W'($urandom);
      run_group("rand", int'($urandom_range(60)), int'($urandom_range(4)), g[0], 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(k + 5);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    tests++;
    if (fill_level !== 3'd4) begin
      fails++;
      $display("FAIL rst_mid_partial: got fill=%0d want 4", fill_level);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (op_bus !== '0 || fill_level !== '0 || bus.out_sum !== '0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_clear: got bus=%h fill=%0d sum=%h valid=%b want zeros",
               op_bus, fill_level, bus.out_sum, bus.out_valid);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) grp[k] = 16'd10;
    run_group("rst_mid_after", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_self_check();
    for (int k = 0; k < N; k++) grp[k] = 16'd1;
    force_zero = 1'b1;
    run_group("sc_bad", 0, 0, 1'b0, 1'b1);
    force_zero = 1'b0;
    tests++;
    if (err_mismatch !== SELF_CHECK) begin
      fails++;
      $display("FAIL sc_flag: got %b want %b", err_mismatch, SELF_CHECK);
    end
    for (int k = 0; k < N; k++) grp[k] = W'($urandom);
    run_group("sc_good", 0, 0, 1'b0, 1'b0);
    tests++;
    if (err_mismatch !== SELF_CHECK) begin
      fails++;
      $display("FAIL sc_sticky: got %b want %b", err_mismatch, SELF_CHECK);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (err_mismatch !== 1'b0) begin
      fails++;
      $display("FAIL sc_rst_clear: got %b want 0", err_mismatch);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_all_ones();
    test_backpressure();
    test_gaps();
    test_random();
    test_reset_mid();
    test_self_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
